bcd_display_scanner: RTL and testbench

Time-multiplexed 7-segment display driver sitting directly downstream of a chain of cascaded decade counters. It takes the packed BCD digit bus and the most-significant stage's terminal-count pulse, and optionally freezes a snapshot of the digits. It scans the digits onto one shared segment bus with one-hot digit enables, leading-zero blanking and a sticky overflow indicator.

---
 rtl/bcd_display_pkg.sv | 26 ++
 rtl/bcd_display_scanner_decoder.sv | 31 +++
 rtl/bcd_display_scanner.sv | 107 ++++++++++
 tb/tb_bcd_display_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared segment encodings and width helpers for the BCD display scanner.
package bcd_display_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int idx_width(input int num_digits);
    return (num_digits < 2) ? 1 : $clog2(num_digits);
  endfunction

  function automatic int div_width(input int refresh_div);
    return (refresh_div < 2) ? 1 : $clog2(refresh_div);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_decoder.sv
// Combinational BCD to 7-segment decoder; codes 10..15 render as a dash.
module bcd_seg_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with snapshot hold, leading-zero
// blanking and a sticky overflow indicator on the MSD decimal point.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    tc_in,
  input  logic                    hold,
  input  logic                    blank_lz,
  input  logic                    clr_ovf,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    ovf
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int DIV_W = div_width(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] snap;
  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              seg_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (!hold) begin
      snap <= digits;
    end
  end

  // Scanning free-runs regardless of hold so the display never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == LAST_DIV) begin
      div <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // A digit is a leading zero when it and all more significant digits are 0
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (snap[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_lz && zero_run;
    end
  end

  always_comb begin
    cur_digit = snap[3:0];
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = snap[4*i +: 4];
        cur_blank = blank_mask[i];
      end
    end
  end

  bcd_seg_decoder u_decoder (
    .value (cur_digit),
    .blank (cur_blank),
    .seg   (seg_next)
  );

  // Set has priority over clear so a coincident terminal count is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (tc_in) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '0;
      dp  <= 1'b0;
    end else begin
      seg <= seg_next;
      an  <= NUM_DIGITS'(1) << idx;
      dp  <= ovf && (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner (4 digits, 4-cycle slots).
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic        tc_in;
  logic        hold;
  logic        blank_lz;
  logic        clr_ovf;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  bcd_display_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digits   (digits),
    .tc_in    (tc_in),
    .hold     (hold),
    .blank_lz (blank_lz),
    .clr_ovf  (clr_ovf),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic h, input logic b);
    digits   = d;
    hold     = h;
    blank_lz = b;
    repeat (2) @(negedge clk);
  endtask

  // Returns at the first sampled cycle of the given digit's slot
  task automatic waitSlot(input int d);
    logic [3:0] target;
    logic [3:0] prev;
    bit         found;
    target = 4'(1 << d);
    prev   = an;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == target && prev != target) found = 1'b1;
      prev = an;
    end
    if (!found) checkOutput("slot_timeout", 32'(an), 32'(target));
  endtask

  logic [6:0] seg_table [16];
  logic [6:0] exp_frame [4];
  int         slot_len;

  initial begin
    seg_table = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    rst = 1'b1; digits = 16'h1234; tc_in = 0; hold = 0; blank_lz = 0; clr_ovf = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_seg", 32'(seg), 32'h00);
    checkOutput("rst_an",  32'(an),  32'h0);
    checkOutput("rst_dp",  32'(dp),  32'h0);
    checkOutput("rst_ovf", 32'(ovf), 32'h0);

    // Reset and first slot
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("first_an",  32'(an),  32'h1);
    checkOutput("first_seg", 32'(seg), 32'h66);
    repeat (3) @(negedge clk);
    checkOutput("rot1_an",  32'(an),  32'h2);
    checkOutput("rot1_seg", 32'(seg), 32'h4F);
    repeat (4) @(negedge clk);
    checkOutput("rot2_an",  32'(an),  32'h4);
    checkOutput("rot2_seg", 32'(seg), 32'h5B);
    repeat (4) @(negedge clk);
    checkOutput("rot3_an",  32'(an),  32'h8);
    checkOutput("rot3_seg", 32'(seg), 32'h06);
    repeat (4) @(negedge clk);
    checkOutput("rot4_an",  32'(an),  32'h1);
    checkOutput("rot4_seg", 32'(seg), 32'h66);

    // Full decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      applyStimulus(16'(v), 1'b0, 1'b0);
      waitSlot(0);
      checkOutput($sformatf("decode_%0d", v), 32'(seg), 32'(seg_table[v]));
    end

    // Leading-zero blanking: expected segs listed for digits 3..0
    applyStimulus(16'h0070, 1'b0, 1'b1);
    exp_frame = '{7'h00, 7'h00, 7'h07, 7'h3F};
    for (int d = 3; d >= 0; d--) begin
      waitSlot(d);
      checkOutput($sformatf("lz70_an%0d", d), 32'(an), 32'(1 << d));
      checkOutput($sformatf("lz70_seg%0d", d), 32'(seg), 32'(exp_frame[3-d]));
    end
    applyStimulus(16'h0000, 1'b0, 1'b1);
    exp_frame = '{7'h00, 7'h00, 7'h00, 7'h3F};
    for (int d = 3; d >= 0; d--) begin
      waitSlot(d);
      checkOutput($sformatf("lz00_seg%0d", d), 32'(seg), 32'(exp_frame[3-d]));
    end
    applyStimulus(16'h0C00, 1'b0, 1'b1);
    exp_frame = '{7'h00, 7'h40, 7'h3F, 7'h3F};
    for (int d = 3; d >= 0; d--) begin
      waitSlot(d);
      checkOutput($sformatf("lzC_seg%0d", d), 32'(seg), 32'(exp_frame[3-d]));
    end

    // Hold freeze
    applyStimulus(16'h5678, 1'b0, 1'b0);
    hold = 1'b1;
    applyStimulus(16'h9999, 1'b1, 1'b0);
    exp_frame = '{7'h6D, 7'h7D, 7'h07, 7'h7F};
    for (int d = 3; d >= 0; d--) begin
      waitSlot(d);
      checkOutput($sformatf("hold_seg%0d", d), 32'(seg), 32'(exp_frame[3-d]));
    end
    hold = 1'b0;
    waitSlot(1);
    checkOutput("unhold_seg1", 32'(seg), 32'h6F);

    // Overflow set, priority and clear
    tc_in = 1'b1;
    @(negedge clk);
    tc_in = 1'b0;
    checkOutput("ovf_set", 32'(ovf), 32'h1);
    waitSlot(3);
    checkOutput("dp_msd", 32'(dp), 32'h1);
    waitSlot(0);
    checkOutput("dp_lsd", 32'(dp), 32'h0);
    tc_in = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    tc_in = 1'b0;
    checkOutput("ovf_set_wins", 32'(ovf), 32'h1);
    @(negedge clk);
    clr_ovf = 1'b0;
    checkOutput("ovf_clear", 32'(ovf), 32'h0);
    waitSlot(3);
    checkOutput("dp_cleared", 32'(dp), 32'h0);

    // Reset mid-operation
    tc_in = 1'b1;
    @(negedge clk);
    tc_in = 1'b0;
    waitSlot(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_seg", 32'(seg), 32'h00);
    checkOutput("mid_rst_an",  32'(an),  32'h0);
    checkOutput("mid_rst_dp",  32'(dp),  32'h0);
    checkOutput("mid_rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_an", 32'(an), 32'h1);
    slot_len = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != 4'h1) break;
      slot_len++;
    end
    checkOutput("post_rst_slot_len", 32'(slot_len), 32'd4);
    checkOutput("post_rst_next_an", 32'(an), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
